// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among three message sources.
// Define ARB_TIMEOUT_EN to build the watchdog that force-releases a silent grant after TIMEOUT_CYCLES.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [2:0] msgdone,
  input  logic [7:0] txdata0,
  input  logic [7:0] txdata1,
  input  logic [7:0] txdata2,
  input  logic [2:0] ldtxdata_in,
  input  logic       txempty,
  output logic [2:0] grant,
  output logic [7:0] txdata,
  output logic       ldtxdata,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t     state_q;
  logic [2:0] grant_q;
  logic [1:0] sel_q;
  logic [1:0] last_q;
  logic       busy_q;

  logic [1:0] pick_d;
  logic       done;
  logic       ld_fwd;
  logic       expire;
  logic [7:0] bus    [3];
  logic [7:0] masked [3];

  assign bus[0] = txdata0;
  assign bus[1] = txdata1;
  assign bus[2] = txdata2;

  // The one-hot grant gates each source bus, so the output mux is a plain AND-OR.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_mux
      assign masked[gi] = bus[gi] & {8{grant_q[gi]}};
    end
  endgenerate

  assign ld_fwd   = (|(ldtxdata_in & grant_q)) & ~reset;
  assign ldtxdata = ld_fwd;
  assign txdata   = reset ? 8'h00 : (masked[0] | masked[1] | masked[2]);
  assign grant    = grant_q;
  assign busy     = busy_q;
  assign done     = |(grant_q & (msgdone | ~req));

  // First requester above the last one served, wrapping around.
  always_comb begin
    pick_d = 2'd0;
    case (last_q)
      2'd0:    pick_d = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    pick_d = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: pick_d = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= 3'b000;
      sel_q   <= 2'd0;
      last_q  <= 2'd2;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            state_q <= ST_GRANT;
            grant_q <= 3'b001 << pick_d;
            sel_q   <= pick_d;
            busy_q  <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (done || expire) begin
            state_q <= ST_RELEASE;
            grant_q <= 3'b000;
            last_q  <= sel_q;
          end
        end
        ST_RELEASE: begin
          // Hold the UART until the last byte has left the holding register.
          if (txempty) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= 3'b000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tcnt_q;
  logic        timeout_q;

  assign expire  = (state_q == ST_GRANT) && (tcnt_q == LIMIT) && !ld_fwd;
  assign timeout = timeout_q;

  // Counts granted cycles since the grant began or since the last forwarded byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q    <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire & ~done;
      if (state_q != ST_GRANT || ld_fwd) begin
        tcnt_q <= 16'd0;
      end else begin
        tcnt_q <= tcnt_q + 16'd1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = |16'(TIMEOUT_CYCLES);
  assign expire             = 1'b0;
  assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table, corner sequences and a randomized run
// against a message-level reference model.
module tb_uart_tx_arbiter;

  localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req;
  logic [2:0] msgdone;
  logic [7:0] txdata0;
  logic [7:0] txdata1;
  logic [7:0] txdata2;
  logic [2:0] ldtxdata_in;
  logic       txempty;
  logic [2:0] grant;
  logic [7:0] txdata;
  logic       ldtxdata;
  logic       busy;
  logic       timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .msgdone     (msgdone),
    .txdata0     (txdata0),
    .txdata1     (txdata1),
    .txdata2     (txdata2),
    .ldtxdata_in (ldtxdata_in),
    .txempty     (txempty),
    .grant       (grant),
    .txdata      (txdata),
    .ldtxdata    (ldtxdata),
    .busy        (busy),
    .timeout     (timeout)
  );

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [2:0] md;
    logic [2:0] ld;
    logic       te;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [2:0] g;
    logic       busy;
    logic [7:0] td;
    logic       ldo;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the UART, whether a released message is still draining,
  // who was served last, and how long the owner has been silent.
  int m_owner;
  int m_last;
  int m_silent;
  bit m_drain;
  bit m_to;

  function automatic vec_t mk(input logic rst, input logic [2:0] rq, input logic [2:0] md,
                              input logic [2:0] ld, input logic te, input logic [7:0] d0,
                              input logic [7:0] d1, input logic [7:0] d2, input logic [2:0] g,
                              input logic b, input logic [7:0] td, input logic ldo);
    vec_t v;
    v.rst = rst; v.req = rq; v.md = md; v.ld = ld; v.te = te;
    v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.g = g; v.busy = b; v.td = td; v.ldo = ldo;
    return v;
  endfunction

  function automatic logic [2:0] onehot(input int i);
    return 3'(1 << i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_drain  = 1'b0;
    m_last   = 2;
    m_silent = 0;
    m_to     = 1'b0;
  endtask

  function automatic logic [2:0] exp_grant();
    return (m_owner >= 0) ? onehot(m_owner) : 3'b000;
  endfunction

  function automatic logic exp_ld();
    if (reset || m_owner < 0) return 1'b0;
    return |(ldtxdata_in & onehot(m_owner));
  endfunction

  function automatic logic [7:0] exp_td();
    if (reset || m_owner < 0) return 8'h00;
    case (m_owner)
      0:       return txdata0;
      1:       return txdata1;
      default: return txdata2;
    endcase
  endfunction

  task automatic model_edge();
    bit fwd;
    bit fin;
    bit starve;
    bit to_n;
    to_n = 1'b0;
    if (reset) begin
      model_reset();
      return;
    end
    if (m_owner >= 0) begin
      fwd    = |(ldtxdata_in & onehot(m_owner));
      fin    = |((msgdone | ~req) & onehot(m_owner));
      starve = TO_EN && !fwd && (m_silent == TO - 1);
      if (fin || starve) begin
        m_last  = m_owner;
        m_owner = -1;
        m_drain = 1'b1;
        to_n    = starve && !fin;
      end else begin
        m_silent = fwd ? 0 : m_silent + 1;
      end
    end else if (m_drain) begin
      if (txempty) m_drain = 1'b0;
    end else if (req != 3'b000) begin
      for (int k = 3; k >= 1; k--) begin
        if (|(req & onehot((m_last + k) % 3))) m_owner = (m_last + k) % 3;
      end
      m_silent = 0;
    end
    m_to = to_n;
  endtask

  task automatic step(input vec_t v, input bit has_exp, input int idx);
    reset = v.rst; req = v.req; msgdone = v.md; ldtxdata_in = v.ld; txempty = v.te;
    txdata0 = v.d0; txdata1 = v.d1; txdata2 = v.d2;
    @(negedge clk);
    chk("grant", grant, exp_grant());
    chk("busy", busy, (m_owner >= 0) || m_drain);
    chk("txdata", txdata, exp_td());
    chk("ldtxdata", ldtxdata, exp_ld());
    chk("timeout", timeout, m_to);
    if (has_exp) begin
      chk($sformatf("vec%0d_grant", idx), grant, v.g);
      chk($sformatf("vec%0d_busy", idx), busy, v.busy);
      chk($sformatf("vec%0d_txdata", idx), txdata, v.td);
      chk($sformatf("vec%0d_ldtxdata", idx), ldtxdata, v.ldo);
      $display("vec %0d: req=%b ld_in=%b -> grant=%b busy=%b txdata=%h ldtxdata=%b",
               idx, v.req, v.ld, grant, busy, txdata, ldtxdata);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  vec_t tbl[21];

  initial begin
    int n;
    int k;
    logic [2:0] order [4];
    logic [2:0] rq_r;

    reset = 1'b1; req = 3'b000; msgdone = 3'b000; ldtxdata_in = 3'b000; txempty = 1'b1;
    txdata0 = 8'h00; txdata1 = 8'h00; txdata2 = 8'h00;
    @(posedge clk);
    #1;
    model_reset();

    // Reset state, with every requester active to show that nothing leaks through.
    step(mk(1, 3'b111, 3'b000, 3'b111, 1, 8'hFF, 8'hFF, 8'hFF, 3'b000, 0, 8'h00, 0), 1'b1, 99);

    tbl[0]  = mk(0, 3'b001, 3'b000, 3'b000, 1, 8'h00, 8'h00, 8'h00, 3'b000, 0, 8'h00, 0);
    tbl[1]  = mk(0, 3'b001, 3'b000, 3'b001, 1, 8'h47, 8'h00, 8'h00, 3'b001, 1, 8'h47, 1);
    tbl[2]  = mk(0, 3'b001, 3'b000, 3'b000, 1, 8'h55, 8'h00, 8'h00, 3'b001, 1, 8'h55, 0);
    tbl[3]  = mk(0, 3'b001, 3'b001, 3'b000, 0, 8'h00, 8'h00, 8'h00, 3'b001, 1, 8'h00, 0);
    tbl[4]  = mk(0, 3'b000, 3'b000, 3'b000, 0, 8'h00, 8'h00, 8'h00, 3'b000, 1, 8'h00, 0);
    tbl[5]  = mk(0, 3'b000, 3'b000, 3'b001, 0, 8'h99, 8'h00, 8'h00, 3'b000, 1, 8'h00, 0);
    tbl[6]  = mk(0, 3'b000, 3'b000, 3'b000, 0, 8'h00, 8'h00, 8'h00, 3'b000, 1, 8'h00, 0);
    tbl[7]  = mk(0, 3'b000, 3'b000, 3'b000, 0, 8'h00, 8'h00, 8'h00, 3'b000, 1, 8'h00, 0);
    tbl[8]  = mk(0, 3'b000, 3'b000, 3'b000, 0, 8'h00, 8'h00, 8'h00, 3'b000, 1, 8'h00, 0);
    tbl[9]  = mk(0, 3'b000, 3'b000, 3'b000, 1, 8'h00, 8'h00, 8'h00, 3'b000, 1, 8'h00, 0);
    tbl[10] = mk(0, 3'b010, 3'b000, 3'b000, 1, 8'h00, 8'h00, 8'h00, 3'b000, 0, 8'h00, 0);
    tbl[11] = mk(0, 3'b110, 3'b000, 3'b100, 1, 8'h00, 8'h3C, 8'hFF, 3'b010, 1, 8'h3C, 0);
    tbl[12] = mk(0, 3'b110, 3'b000, 3'b110, 1, 8'h00, 8'h3D, 8'hFF, 3'b010, 1, 8'h3D, 1);
    tbl[13] = mk(0, 3'b100, 3'b000, 3'b000, 1, 8'h00, 8'h3E, 8'h00, 3'b010, 1, 8'h3E, 0);
    tbl[14] = mk(0, 3'b101, 3'b000, 3'b000, 1, 8'h00, 8'h00, 8'h00, 3'b000, 1, 8'h00, 0);
    tbl[15] = mk(0, 3'b101, 3'b000, 3'b000, 1, 8'h00, 8'h00, 8'h00, 3'b000, 0, 8'h00, 0);
    tbl[16] = mk(0, 3'b101, 3'b001, 3'b000, 1, 8'h00, 8'h00, 8'hA5, 3'b100, 1, 8'hA5, 0);
    tbl[17] = mk(0, 3'b101, 3'b100, 3'b000, 1, 8'h00, 8'h00, 8'hA6, 3'b100, 1, 8'hA6, 0);
    tbl[18] = mk(0, 3'b001, 3'b000, 3'b000, 1, 8'h00, 8'h00, 8'h00, 3'b000, 1, 8'h00, 0);
    tbl[19] = mk(0, 3'b001, 3'b000, 3'b000, 1, 8'h00, 8'h00, 8'h00, 3'b000, 0, 8'h00, 0);
    tbl[20] = mk(0, 3'b001, 3'b000, 3'b001, 1, 8'h5A, 8'h00, 8'h00, 3'b001, 1, 8'h5A, 1);
    for (int i = 0; i < 21; i++) step(tbl[i], 1'b1, i);

    // Round robin with all requesters held high, two bytes per message.
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    step(mk(1, 3'b111, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 0);
    for (int m = 0; m < 4; m++) begin
      n = 0;
      while (grant === 3'b000 && n < 12) begin
        step(mk(0, 3'b111, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 0);
        n++;
      end
      chk($sformatf("rr_order%0d", m), grant, order[m]);
      if (m > 0) chk($sformatf("rr_gap%0d_ge2", m), (n >= 2), 1);
      $display("rr msg %0d: grant=%b after %0d idle cycles", m, grant, n);
      step(mk(0, 3'b111, 0, onehot(m % 3), 1, 8'h10, 8'h20, 8'h30, 0, 0, 0, 0), 1'b0, 0);
      step(mk(0, 3'b111, 0, onehot(m % 3), 1, 8'h11, 8'h21, 8'h31, 0, 0, 0, 0), 1'b0, 0);
      step(mk(0, 3'b111, onehot(m % 3), 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 0);
    end

    // Reset in the middle of a message owned by requester 1.
    step(mk(1, 3'b000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 0);
    step(mk(0, 3'b010, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 0);
    chk("midrst_grant_before", grant, 3'b010);
    step(mk(1, 3'b010, 0, 3'b010, 1, 0, 8'hC3, 0, 0, 0, 0, 0), 1'b0, 0);
    chk("midrst_grant_after", grant, 3'b000);
    step(mk(0, 3'b011, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 0);
    chk("midrst_first_winner", grant, 3'b001);
    $display("reset mid-message: grant after recovery=%b", grant);

`ifdef ARB_TIMEOUT_EN
    // Silent owner is forced off after TO granted cycles.
    step(mk(1, 3'b000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 0);
    step(mk(0, 3'b011, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 0);
    chk("to_first_grant", grant, 3'b001);
    k = 1;
    while (k <= 20) begin
      step(mk(0, 3'b011, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 0);
      if (timeout === 1'b1) break;
      k++;
    end
    chk("to_delay", k, TO);
    step(mk(0, 3'b011, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 0);
    chk("to_one_cycle", timeout, 1'b0);
    step(mk(0, 3'b011, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 0);
    chk("to_next_owner", grant, 3'b010);
    $display("timeout: pulse after %0d cycles, next grant=%b", k, grant);
`endif

    // Randomized traffic against the reference model.
    rq_r = 3'b000;
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < 3; r++) begin
        if (rq_r[r] == 1'b0) begin
          if ($urandom_range(0, 3) == 0) rq_r[r] = 1'b1;
        end else if ($urandom_range(0, 31) == 0) begin
          rq_r[r] = 1'b0;
        end
      end
      step(mk(($urandom_range(0, 299) == 0), rq_r,
              (($urandom_range(0, 9) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000),
              3'($urandom_range(0, 7) & $urandom_range(0, 7)),
              ($urandom_range(0, 2) != 0),
              8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0, 0), 1'b0, 0);
    end
    $display("random phase done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
